// File: rtl/mem_stage_access.sv
// MEM-stage access controller: issues the data-memory bus transaction for the
// instruction in EX/MEM, stalls the front of the pipe while it is in flight,
// and loads the MEM/WB latch with the result, a bubble, or a fault bubble.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | no access outstanding; EX/MEM instruction is decoded this cycle
// S_WAIT | bus request held, waiting for mem_ready or the timeout limit
module mem_stage_access #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic [31:0] ALUOut_MEM,
   input  logic [4:0]  Rw_MEM,
   input  logic [1:0]  MemtoReg_MEM,
   input  logic        RegWrite_MEM,
   input  logic [31:0] rt_MEM,
   input  logic [31:0] PC_MEM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        mem_stall,
   output logic        mem_fault,
   output logic        RegWrite_WB,
   output logic [1:0]  MemtoReg_WB,
   output logic [4:0]  Rw_WB,
   output logic [31:0] ALUOut_WB,
   output logic [31:0] MemData_WB,
   output logic [31:0] PC_WB
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        fault_q, fault_d;
   logic [4:0]  cap_rw_q, cap_rw_d;
   logic [1:0]  cap_m2r_q, cap_m2r_d;
   logic        cap_rwe_q, cap_rwe_d;
   logic [31:0] cap_pc_q, cap_pc_d;
   logic        wb_rwe_q, wb_rwe_d;
   logic [1:0]  wb_m2r_q, wb_m2r_d;
   logic [4:0]  wb_rw_q, wb_rw_d;
   logic [31:0] wb_alu_q, wb_alu_d;
   logic [31:0] wb_md_q, wb_md_d;
   logic [31:0] wb_pc_q, wb_pc_d;

   logic acc, mis;

   assign acc = MemRead_MEM | MemWrite_MEM;
   assign mis = acc & (ALUOut_MEM[1:0] != 2'b00);

   // Register bank: FSM, timeout counter, bus, captured fields and MEM/WB latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         fault_q   <= 1'b0;
         cap_rw_q  <= '0;
         cap_m2r_q <= '0;
         cap_rwe_q <= 1'b0;
         cap_pc_q  <= '0;
         wb_rwe_q  <= 1'b0;
         wb_m2r_q  <= '0;
         wb_rw_q   <= '0;
         wb_alu_q  <= '0;
         wb_md_q   <= '0;
         wb_pc_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         fault_q   <= fault_d;
         cap_rw_q  <= cap_rw_d;
         cap_m2r_q <= cap_m2r_d;
         cap_rwe_q <= cap_rwe_d;
         cap_pc_q  <= cap_pc_d;
         wb_rwe_q  <= wb_rwe_d;
         wb_m2r_q  <= wb_m2r_d;
         wb_rw_q   <= wb_rw_d;
         wb_alu_q  <= wb_alu_d;
         wb_md_q   <= wb_md_d;
         wb_pc_q   <= wb_pc_d;
      end
   end

   // Next-state logic; MEM/WB defaults to an all-zero bubble every cycle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      fault_d   = 1'b0;
      cap_rw_d  = cap_rw_q;
      cap_m2r_d = cap_m2r_q;
      cap_rwe_d = cap_rwe_q;
      cap_pc_d  = cap_pc_q;
      wb_rwe_d  = 1'b0;
      wb_m2r_d  = '0;
      wb_rw_d   = '0;
      wb_alu_d  = '0;
      wb_md_d   = '0;
      wb_pc_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (!acc) begin
               wb_rwe_d = RegWrite_MEM;
               wb_m2r_d = MemtoReg_MEM;
               wb_rw_d  = Rw_MEM;
               wb_alu_d = ALUOut_MEM;
               wb_pc_d  = PC_MEM;
            end else if (mis) begin
               // Faulting instruction keeps its PC so the handler can find it.
               fault_d = 1'b1;
               wb_pc_d = PC_MEM;
            end else begin
               state_d   = S_WAIT;
               cnt_d     = '0;
               req_d     = 1'b1;
               we_d      = MemWrite_MEM;
               addr_d    = ALUOut_MEM;
               wdata_d   = rt_MEM;
               cap_rw_d  = Rw_MEM;
               cap_m2r_d = MemtoReg_MEM;
               cap_rwe_d = RegWrite_MEM;
               cap_pc_d  = PC_MEM;
            end
         end
         S_WAIT: begin
            if (mem_ready) begin
               state_d  = S_IDLE;
               req_d    = 1'b0;
               wb_rwe_d = cap_rwe_q;
               wb_m2r_d = cap_m2r_q;
               wb_rw_d  = cap_rw_q;
               wb_alu_d = addr_q;
               wb_md_d  = we_q ? 32'h0 : mem_rdata;
               wb_pc_d  = cap_pc_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Stall is gated by reset so an aborted access releases the pipe at once.
   always_comb begin
      mem_stall = 1'b0;
      if (reset) begin
         case (state_q)
            S_IDLE:  mem_stall = acc & ~mis;
            S_WAIT:  mem_stall = ~mem_ready & (cnt_q != CNT_LAST);
            default: mem_stall = 1'b0;
         endcase
      end
   end

   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_fault   = fault_q;
   assign RegWrite_WB = wb_rwe_q;
   assign MemtoReg_WB = wb_m2r_q;
   assign Rw_WB       = wb_rw_q;
   assign ALUOut_WB   = wb_alu_q;
   assign MemData_WB  = wb_md_q;
   assign PC_WB       = wb_pc_q;

endmodule

// File: tb/tb_mem_stage_access.sv
module tb_mem_stage_access;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        MemRead_MEM = 1'b0, MemWrite_MEM = 1'b0, RegWrite_MEM = 1'b0;
   logic [31:0] ALUOut_MEM = '0, rt_MEM = '0, PC_MEM = '0, mem_rdata = '0;
   logic [4:0]  Rw_MEM = '0;
   logic [1:0]  MemtoReg_MEM = '0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, mem_stall, mem_fault, RegWrite_WB;
   logic [31:0] mem_addr, mem_wdata, ALUOut_WB, MemData_WB, PC_WB;
   logic [1:0]  MemtoReg_WB;
   logic [4:0]  Rw_WB;

   int n_cmp = 0;
   int n_err = 0;

   mem_stage_access #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(rst_n),
      .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
      .ALUOut_MEM(ALUOut_MEM), .Rw_MEM(Rw_MEM), .MemtoReg_MEM(MemtoReg_MEM),
      .RegWrite_MEM(RegWrite_MEM), .rt_MEM(rt_MEM), .PC_MEM(PC_MEM),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
      .mem_fault(mem_fault), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
      .Rw_WB(Rw_WB), .ALUOut_WB(ALUOut_WB), .MemData_WB(MemData_WB), .PC_WB(PC_WB)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one optional outstanding access with an age.
   bit          m_busy;
   int          m_age;
   logic [4:0]  c_rw;
   logic [1:0]  c_m2r;
   logic        c_rwe;
   logic [31:0] c_pc;
   logic        e_req, e_we, e_fault, e_rwe;
   logic [31:0] e_addr, e_wdata, e_alu, e_md, e_pc;
   logic [1:0]  e_m2r;
   logic [4:0]  e_rw;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_age = 0;
         c_rw = 0; c_m2r = 0; c_rwe = 0; c_pc = 0;
         e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_fault = 0;
         e_rwe = 0; e_m2r = 0; e_rw = 0; e_alu = 0; e_md = 0; e_pc = 0;
      end else begin
         e_fault = 0;
         e_rwe = 0; e_m2r = 0; e_rw = 0; e_alu = 0; e_md = 0; e_pc = 0;
         if (!m_busy) begin
            if (!(MemRead_MEM || MemWrite_MEM)) begin
               e_rwe = RegWrite_MEM; e_m2r = MemtoReg_MEM; e_rw = Rw_MEM;
               e_alu = ALUOut_MEM; e_pc = PC_MEM;
            end else if (ALUOut_MEM % 4 != 0) begin
               e_fault = 1; e_pc = PC_MEM;
            end else begin
               m_busy = 1; m_age = 0;
               e_req = 1; e_we = MemWrite_MEM; e_addr = ALUOut_MEM; e_wdata = rt_MEM;
               c_rw = Rw_MEM; c_m2r = MemtoReg_MEM; c_rwe = RegWrite_MEM; c_pc = PC_MEM;
            end
         end else if (mem_ready) begin
            m_busy = 0; e_req = 0;
            e_rwe = c_rwe; e_m2r = c_m2r; e_rw = c_rw; e_alu = e_addr; e_pc = c_pc;
            e_md = e_we ? 32'h0 : mem_rdata;
         end else if (m_age == TO - 1) begin
            m_busy = 0; e_req = 0; e_fault = 1;
         end else begin
            m_age++;
         end
      end
   end

   // Compare process: every negedge, all outputs against the reference.
   always @(negedge clk) begin
      logic exp_stall;
      if (!rst_n) exp_stall = 0;
      else if (!m_busy) exp_stall = (MemRead_MEM || MemWrite_MEM) && (ALUOut_MEM % 4 == 0);
      else exp_stall = !mem_ready && (m_age != TO - 1);
      chk("stall", 32'(mem_stall), 32'(exp_stall));
      chk("req", 32'(mem_req), 32'(e_req));
      if (e_req) begin
         chk("we", 32'(mem_we), 32'(e_we));
         chk("addr", mem_addr, e_addr);
         chk("wdata", mem_wdata, e_wdata);
      end
      chk("fault", 32'(mem_fault), 32'(e_fault));
      chk("regwrite_wb", 32'(RegWrite_WB), 32'(e_rwe));
      chk("memtoreg_wb", 32'(MemtoReg_WB), 32'(e_m2r));
      chk("rw_wb", 32'(Rw_WB), 32'(e_rw));
      chk("aluout_wb", ALUOut_WB, e_alu);
      chk("memdata_wb", MemData_WB, e_md);
      chk("pc_wb", PC_WB, e_pc);
   end

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [4:0] rw, input logic [1:0] m2r, input logic rwe,
                        input logic [31:0] rt, input logic [31:0] pc,
                        input logic rdy, input logic [31:0] rdata);
      MemRead_MEM = rd; MemWrite_MEM = wr; ALUOut_MEM = addr; Rw_MEM = rw;
      MemtoReg_MEM = m2r; RegWrite_MEM = rwe; rt_MEM = rt; PC_MEM = pc;
      mem_ready = rdy; mem_rdata = rdata;
   endtask

   task automatic nop(input logic rdy, input logic [31:0] rdata);
      drive(1'b0, 1'b0, 32'h0, 5'd0, 2'd0, 1'b0, 32'h0, 32'h0, rdy, rdata);
   endtask

   // Issue one instruction, then idle 8 cycles, counting bus/stall/fault/WB events.
   task automatic run_mem(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] pc, input logic [4:0] rw,
                          input logic rwe, input int rdy_at, input logic [31:0] rdata,
                          input int snap_at,
                          output int n_stall, output int n_req, output int n_fault,
                          output int n_wb, output logic s_rwe, output logic [4:0] s_rw,
                          output logic [31:0] s_md, output logic [31:0] s_alu,
                          output logic b_we, output logic [31:0] b_addr,
                          output logic [31:0] b_wdata);
      n_stall = 0; n_req = 0; n_fault = 0; n_wb = 0;
      s_rwe = 0; s_rw = 0; s_md = 0; s_alu = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      drive(rd, wr, addr, rw, 2'd1, rwe, rt, pc, 1'b0, 32'h0);
      #1; if (mem_stall) n_stall++;
      @(posedge clk); #2;
      for (int c = 0; c < 8; c++) begin
         if (mem_req) begin n_req++; b_we = mem_we; b_addr = mem_addr; b_wdata = mem_wdata; end
         if (mem_fault) n_fault++;
         if (RegWrite_WB) n_wb++;
         if (c == snap_at) begin s_rwe = RegWrite_WB; s_rw = Rw_WB; s_md = MemData_WB; s_alu = ALUOut_WB; end
         nop(c == rdy_at, rdata);
         #1; if (mem_stall) n_stall++;
         @(posedge clk); #2;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ns, nr, nf, nw, prob;
      logic srwe, bwe;
      logic [4:0] srw;
      logic [31:0] smd, salu, baddr, bwd, a;

      // Reset for 3 cycles, then an ALU instruction.
      nop(1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_req", 32'(mem_req), 32'h0);
      chk("rst_regwrite", 32'(RegWrite_WB), 32'h0);
      chk("rst_aluout", ALUOut_WB, 32'h0);
      drive(1'b0, 1'b0, 32'h1234, 5'd5, 2'd0, 1'b1, 32'h0, 32'h10, 1'b0, 32'h0);
      rst_n = 1'b1;
      #1; chk("alu_stall", 32'(mem_stall), 32'h0);
      @(posedge clk); #2;
      chk("alu_regwrite", 32'(RegWrite_WB), 32'h1);
      chk("alu_rw", 32'(Rw_WB), 32'h5);
      chk("alu_aluout", ALUOut_WB, 32'h1234);
      chk("alu_memdata", MemData_WB, 32'h0);

      // Load at 0x40, ready three cycles after the request.
      run_mem(1, 0, 32'h40, 32'h0, 32'h100, 5'd7, 1, 3, 32'hDEADBEEF, 4,
              ns, nr, nf, nw, srwe, srw, smd, salu, bwe, baddr, bwd);
      chk("ld_addr", baddr, 32'h40);
      chk("ld_we", 32'(bwe), 32'h0);
      chk("ld_stall_cycles", ns, 4);
      chk("ld_memdata", smd, 32'hDEADBEEF);
      chk("ld_rw", 32'(srw), 32'h7);
      chk("ld_aluout", salu, 32'h40);
      chk("ld_wb_writes", nw, 1);
      chk("ld_fault", nf, 0);

      // Store at 0x80, ready immediately.
      run_mem(0, 1, 32'h80, 32'hA5A5A5A5, 32'h104, 5'd3, 0, 0, 32'h12345678, 1,
              ns, nr, nf, nw, srwe, srw, smd, salu, bwe, baddr, bwd);
      chk("st_we", 32'(bwe), 32'h1);
      chk("st_wdata", bwd, 32'hA5A5A5A5);
      chk("st_stall_cycles", ns, 1);
      chk("st_regwrite", 32'(srwe), 32'h0);
      chk("st_memdata", smd, 32'h0);

      // Read and write both set: the store wins.
      run_mem(1, 1, 32'h84, 32'h11223344, 32'h108, 5'd9, 1, 1, 32'hCAFEF00D, 2,
              ns, nr, nf, nw, srwe, srw, smd, salu, bwe, baddr, bwd);
      chk("rw_we", 32'(bwe), 32'h1);
      chk("rw_memdata", smd, 32'h0);
      chk("rw_stall_cycles", ns, 2);

      // Misaligned load.
      run_mem(1, 0, 32'h42, 32'h0, 32'h10C, 5'd4, 1, -1, 32'h0, 0,
              ns, nr, nf, nw, srwe, srw, smd, salu, bwe, baddr, bwd);
      chk("mis_req", nr, 0);
      chk("mis_fault", nf, 1);
      chk("mis_regwrite", 32'(srwe), 32'h0);
      chk("mis_stall", ns, 0);
      chk("mis_wb_writes", nw, 0);

      // Timeout with no ready.
      run_mem(1, 0, 32'h200, 32'h0, 32'h110, 5'd6, 1, -1, 32'h0, 4,
              ns, nr, nf, nw, srwe, srw, smd, salu, bwe, baddr, bwd);
      chk("to_req_cycles", nr, TO);
      chk("to_fault", nf, 1);
      chk("to_wb_writes", nw, 0);
      chk("to_stall_cycles", ns, TO);

      // Ready on the last allowed cycle completes normally.
      run_mem(1, 0, 32'h204, 32'h0, 32'h114, 5'd8, 1, TO - 1, 32'h0BADCAFE, TO,
              ns, nr, nf, nw, srwe, srw, smd, salu, bwe, baddr, bwd);
      chk("last_fault", nf, 0);
      chk("last_wb_writes", nw, 1);
      chk("last_memdata", smd, 32'h0BADCAFE);

      // Reset in the middle of WAIT.
      drive(1'b1, 1'b0, 32'h300, 5'd2, 2'd1, 1'b1, 32'h0, 32'h118, 1'b0, 32'h0);
      @(posedge clk); #2;
      nop(1'b0, 32'h0);
      @(posedge clk); #2;
      #1; chk("wait_stall_before_rst", 32'(mem_stall), 32'h1);
      drive(1'b1, 1'b0, 32'h300, 5'd2, 2'd1, 1'b1, 32'h0, 32'h118, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_wait_req", 32'(mem_req), 32'h0);
      chk("rst_wait_stall", 32'(mem_stall), 32'h0);
      @(posedge clk); #2;
      nop(1'b0, 32'h0);
      rst_n = 1'b1;
      nf = 0; nw = 0;
      repeat (3) begin
         @(posedge clk); #2;
         if (mem_fault) nf++;
         if (RegWrite_WB) nw++;
      end
      chk("post_rst_fault", nf, 0);
      chk("post_rst_wb", nw, 0);
      run_mem(1, 0, 32'h304, 32'h0, 32'h11C, 5'd11, 1, 1, 32'h5555AAAA, 2,
              ns, nr, nf, nw, srwe, srw, smd, salu, bwe, baddr, bwd);
      chk("post_rst_memdata", smd, 32'h5555AAAA);
      chk("post_rst_rw", 32'(srw), 32'd11);

      // Randomised traffic against the reference.
      prob = 50;
      for (int i = 0; i < 3000; i++) begin
         int kind;
         if (i % 500 == 0) begin
            case ($urandom_range(0, 3))
               0: prob = 5;
               1: prob = 30;
               2: prob = 70;
               default: prob = 100;
            endcase
         end
         kind = $urandom_range(0, 3);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         drive(kind == 1 || kind == 3, kind == 2 || kind == 3, a, 5'($urandom),
               2'($urandom), 1'($urandom), $urandom, $urandom,
               ($urandom_range(0, 99) < prob), $urandom);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 399) == 0) begin
            #1; rst_n = 1'b0;
         end
         @(posedge clk); #2;
      end
      rst_n = 1'b1;
      nop(1'b0, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
